// File: rtl/ram_bist_ctrl.sv
// Two-pass march-style self-test initiator for a 256x32 RAM.
// Writes address-derived patterns, reads them back and logs mismatches.
module ram_bist_ctrl #(
    parameter int          RD_LAT = 1,
    parameter logic [31:0] SEED   = 32'hA5A5_5A5A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        WR,
    output logic [7:0]  address,
    output logic [31:0] Din,
    input  logic [31:0] Dout,
    output logic [9:0]  err_count,
    output logic [7:0]  first_fail_addr,
    output logic [31:0] first_fail_data,
    output logic        first_fail_pass
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR0  = 3'd1;
    localparam logic [2:0] S_RD0  = 3'd2;
    localparam logic [2:0] S_DR0  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;
    localparam logic [2:0] S_RD1  = 3'd5;
    localparam logic [2:0] S_DR1  = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [1:0] DR_LAST = 2'(RD_LAT > 0 ? RD_LAT - 1 : 0);

    logic [2:0]  state, state_n;
    logic [1:0]  dr_cnt, dr_cnt_n;
    logic        iss_v, iss_v_n;
    logic        iss_p, iss_p_n;
    logic [7:0]  addr_n;
    logic [31:0] din_n;
    logic        wr_n;
    logic        hi;
    logic        accept;
    logic        to_pass1;
    logic        to_done;

    logic        tail_v;
    logic        tail_p;
    logic [7:0]  tail_a;
    logic [31:0] exp_word;
    logic        mism;
    logic [9:0]  err_n;
    logic [7:0]  ffa_n;
    logic [31:0] ffd_n;
    logic        ffp_n;

    function automatic logic [31:0] pat(input logic [7:0] a, input logic inv);
        logic [31:0] b;
        b = {a, a, a, a} ^ SEED;
        return inv ? ~b : b;
    endfunction

    // Sequencer: one address per cycle through write, read and drain phases
    always_comb begin
        state_n  = state;
        dr_cnt_n = 2'd0;
        addr_n   = 8'd0;
        din_n    = 32'd0;
        wr_n     = 1'b0;
        iss_v_n  = 1'b0;
        iss_p_n  = 1'b0;
        to_pass1 = 1'b0;
        to_done  = 1'b0;
        hi       = (state == S_WR1) || (state == S_RD1) || (state == S_DR1);
        accept   = ((state == S_IDLE) || (state == S_DONE)) && start;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_WR0;
                    wr_n    = 1'b1;
                    din_n   = pat(8'h00, 1'b0);
                end
            end
            S_WR0, S_WR1: begin
                if (address == 8'hFF) begin
                    state_n = hi ? S_RD1 : S_RD0;
                    iss_v_n = 1'b1;
                    iss_p_n = hi;
                end else begin
                    addr_n = 8'(address + 8'd1);
                    wr_n   = 1'b1;
                    din_n  = pat(addr_n, hi);
                end
            end
            S_RD0, S_RD1: begin
                if (address == 8'hFF) begin
                    if (RD_LAT == 0) begin
                        to_pass1 = !hi;
                        to_done  = hi;
                    end else begin
                        state_n = hi ? S_DR1 : S_DR0;
                    end
                end else begin
                    addr_n  = 8'(address + 8'd1);
                    iss_v_n = 1'b1;
                    iss_p_n = hi;
                end
            end
            S_DR0, S_DR1: begin
                if (dr_cnt == DR_LAST) begin
                    to_pass1 = !hi;
                    to_done  = hi;
                end else begin
                    dr_cnt_n = 2'(dr_cnt + 2'd1);
                end
            end
        endcase
        if (to_pass1) begin
            state_n = S_WR1;
            wr_n    = 1'b1;
            din_n   = pat(8'h00, 1'b1);
        end
        if (to_done) begin
            state_n = S_DONE;
        end
    end

    // The issue register (address plus iss_v/iss_p) is the head of the
    // read tracker; RD_LAT further stages line it up with Dout.
    if (RD_LAT == 0) begin : g_nopipe
        assign tail_v = iss_v;
        assign tail_p = iss_p;
        assign tail_a = address;
    end else begin : g_pipe
        logic [RD_LAT-1:0] pv;
        logic [RD_LAT-1:0] pp;
        logic [7:0]        pa [RD_LAT];

        always_ff @(posedge CLK) begin
            if (RST) begin
                pv <= '0;
                pp <= '0;
                for (int i = 0; i < RD_LAT; i++) begin
                    pa[i] <= 8'd0;
                end
            end else begin
                pv[0] <= iss_v;
                pp[0] <= iss_p;
                pa[0] <= address;
                for (int i = 1; i < RD_LAT; i++) begin
                    pv[i] <= pv[i-1];
                    pp[i] <= pp[i-1];
                    pa[i] <= pa[i-1];
                end
            end
        end

        assign tail_v = pv[RD_LAT-1];
        assign tail_p = pp[RD_LAT-1];
        assign tail_a = pa[RD_LAT-1];
    end

    always_comb begin
        exp_word = pat(tail_a, tail_p);
        mism     = tail_v && (Dout != exp_word);
        err_n    = 10'(err_count + 10'(mism));
        ffa_n    = first_fail_addr;
        ffd_n    = first_fail_data;
        ffp_n    = first_fail_pass;
        if (mism && (err_count == 10'd0)) begin
            ffa_n = tail_a;
            ffd_n = Dout;
            ffp_n = tail_p;
        end
        if (accept) begin
            err_n = 10'd0;
            ffa_n = 8'd0;
            ffd_n = 32'd0;
            ffp_n = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= S_IDLE;
            dr_cnt          <= 2'd0;
            iss_v           <= 1'b0;
            iss_p           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            WR              <= 1'b0;
            address         <= 8'd0;
            Din             <= 32'd0;
            err_count       <= 10'd0;
            first_fail_addr <= 8'd0;
            first_fail_data <= 32'd0;
            first_fail_pass <= 1'b0;
        end else begin
            state           <= state_n;
            dr_cnt          <= dr_cnt_n;
            iss_v           <= iss_v_n;
            iss_p           <= iss_p_n;
            busy            <= (state_n != S_IDLE) && (state_n != S_DONE);
            done            <= (state_n == S_DONE);
            pass            <= (state_n == S_DONE) && (err_n == 10'd0);
            WR              <= wr_n;
            address         <= addr_n;
            Din             <= din_n;
            err_count       <= err_n;
            first_fail_addr <= ffa_n;
            first_fail_data <= ffd_n;
            first_fail_pass <= ffp_n;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboarded bench: behavioural fault-injecting RAMs around two BIST
// instances (read latency 1 and 2), random faults and stray start pulses.
module tb_ram_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, start2;
    logic        busy, done, pass, wr;
    logic        busy2, done2, pass2, wr2;
    logic [7:0]  address, address2;
    logic [31:0] din, din2, dout, dout2;
    logic [9:0]  err_count, err_count2;
    logic [7:0]  ffa, ffa2;
    logic [31:0] ffd, ffd2;
    logic        ffp, ffp2;

    ram_bist_ctrl #(.RD_LAT(1), .SEED(32'hA5A5_5A5A)) u_dut (
        .CLK(clk), .RST(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .WR(wr), .address(address), .Din(din), .Dout(dout),
        .err_count(err_count), .first_fail_addr(ffa),
        .first_fail_data(ffd), .first_fail_pass(ffp)
    );

    ram_bist_ctrl #(.RD_LAT(2), .SEED(32'hA5A5_5A5A)) u_dut2 (
        .CLK(clk), .RST(rst), .start(start2), .busy(busy2), .done(done2),
        .pass(pass2), .WR(wr2), .address(address2), .Din(din2), .Dout(dout2),
        .err_count(err_count2), .first_fail_addr(ffa2),
        .first_fail_data(ffd2), .first_fail_pass(ffp2)
    );

    // RAM 1: one-cycle read, per-word stuck-at masks applied on read
    logic [31:0] mem  [256];
    logic [31:0] sa0  [256];
    logic [31:0] sa1  [256];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (wr) mem[address] <= din;
        rd1 <= (mem[address] & ~sa0[address]) | sa1[address];
    end
    assign dout = rd1;

    // RAM 2: two-cycle read, whole data bus inverted on read
    logic [31:0] mem2 [256];
    logic [31:0] rd2a, rd2b;
    always @(posedge clk) begin
        if (wr2) mem2[address2] <= din2;
        rd2a <= ~mem2[address2];
        rd2b <= rd2a;
    end
    assign dout2 = rd2b;

    typedef struct {
        int          cycles;
        int          errs;
        logic [7:0]  fa;
        logic [31:0] fd;
        logic        fp;
    } res_t;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic        p;
    } wr_t;

    res_t rq[$];
    res_t rq2[$];
    wr_t  wq[$];
    int   total = 0;
    int   bad = 0;
    bit   aborting = 0;

    function automatic logic [31:0] patt(input int a, input int p);
        logic [7:0]  b8;
        logic [31:0] b;
        b8 = 8'(a);
        b = {b8, b8, b8, b8} ^ 32'hA5A5_5A5A;
        return (p != 0) ? ~b : b;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Reference: what a full two-pass sweep must report given the fault set
    function automatic res_t model(input int lat, input bit invert);
        res_t r;
        logic [31:0] e, g;
        r.cycles = 2 * (512 + lat);
        r.errs = 0;
        r.fa = 8'd0;
        r.fd = 32'd0;
        r.fp = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 256; a++) begin
                e = patt(a, p);
                g = invert ? ~e : ((e & ~sa0[a]) | sa1[a]);
                if (g != e) begin
                    if (r.errs == 0) begin
                        r.fa = 8'(a);
                        r.fd = g;
                        r.fp = p[0];
                    end
                    r.errs++;
                end
            end
        end
        return r;
    endfunction

    int  bcnt1 = 0;
    int  bcnt2 = 0;
    bit  pb1 = 0;
    bit  pb2 = 0;

    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (rst) begin
            bcnt1 = 0;
            pb1 = 0;
        end else begin
            if (wr) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_extra: got addr %0h none expected", address);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(address), 32'(w.a));
                    check("wr_data", din, w.d);
                    if (address == 8'h36)
                        check("din_36", din, w.p ? 32'h6C6C9393 : 32'h93936C6C);
                end
            end
            if (busy) bcnt1++;
            if (pb1 && !busy && !aborting) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL result_extra: got completion none expected");
                end else begin
                    r = rq.pop_front();
                    check("busy_cycles", 32'(bcnt1), 32'(r.cycles));
                    check("done", 32'(done), 32'd1);
                    check("pass", 32'(pass), 32'(r.errs == 0));
                    check("err_count", 32'(err_count), 32'(r.errs));
                    check("ff_addr", 32'(ffa), 32'(r.fa));
                    check("ff_data", ffd, r.fd);
                    check("ff_pass", 32'(ffp), 32'(r.fp));
                end
            end
            if (pb1 && !busy) bcnt1 = 0;
            pb1 = busy;
        end
    end

    always @(negedge clk) begin
        res_t r;
        if (rst) begin
            bcnt2 = 0;
            pb2 = 0;
        end else begin
            if (busy2) bcnt2++;
            if (pb2 && !busy2) begin
                if (rq2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL result2_extra: got completion none expected");
                end else begin
                    r = rq2.pop_front();
                    check("busy_cycles2", 32'(bcnt2), 32'(r.cycles));
                    check("done2", 32'(done2), 32'd1);
                    check("pass2", 32'(pass2), 32'(r.errs == 0));
                    check("err_count2", 32'(err_count2), 32'(r.errs));
                    check("ff_addr2", 32'(ffa2), 32'(r.fa));
                    check("ff_data2", ffd2, r.fd);
                    check("ff_pass2", 32'(ffp2), 32'(r.fp));
                end
                bcnt2 = 0;
            end
            pb2 = busy2;
        end
    end

    task automatic push_writes(input int passes);
        wr_t w;
        for (int p = 0; p < passes; p++) begin
            for (int a = 0; a < 256; a++) begin
                w.a = 8'(a);
                w.d = patt(a, p);
                w.p = p[0];
                wq.push_back(w);
            end
        end
    endtask

    task automatic run1(input int spur);
        int n;
        rq.push_back(model(1, 1'b0));
        push_writes(2);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(done && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
            if (n == spur) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n++;
            end
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL timeout1: got no done after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_faults();
        for (int a = 0; a < 256; a++) begin
            sa0[a] = 32'd0;
            sa1[a] = 32'd0;
        end
    endtask

    initial begin
        int n;
        int nf;
        int fa;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_ffa", 32'(ffa), 32'd0);
        check("rst_ffd", ffd, 32'd0);
        check("rst_ffp", 32'(ffp), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // clean run with a stray start in the middle
        run1(300);

        // stuck-at-1 on bit 0 of word 0x5C
        sa1[8'h5C] = 32'h1;
        run1(0);
        check("sa1_err", 32'(err_count), 32'd1);
        check("sa1_ffa", 32'(ffa), 32'h5C);
        check("sa1_ffd", ffd, 32'hF9F90607);
        check("sa1_ffp", 32'(ffp), 32'd0);
        check("sa1_pass", 32'(pass), 32'd0);
        clear_faults();

        // reset in the middle of the pass-0 read sweep
        sa1[3] = 32'h2;
        push_writes(1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(busy && !wr && address > 8'd40) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("in_rd0", {30'd0, busy, wr}, 32'h2);
        check("pre_rst_err", 32'(err_count), 32'd1);
        aborting = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wr", 32'(wr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        check("mid_rst_addr", 32'(address), 32'd0);
        check("mid_rst_ffa", 32'(ffa), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        aborting = 1'b0;
        wq.delete();
        clear_faults();
        run1(0);

        // random fault sets and stray starts
        for (int k = 0; k < 4; k++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                fa = $urandom_range(0, 255);
                if ($urandom_range(0, 1) == 1)
                    sa1[fa] = sa1[fa] | (32'h1 << $urandom_range(0, 31));
                else
                    sa0[fa] = sa0[fa] | (32'h1 << $urandom_range(0, 31));
            end
            run1(($urandom_range(0, 1) == 1) ? $urandom_range(2, 1020) : 0);
        end
        clear_faults();

        // latency-2 RAM with every read inverted
        rq2.push_back(model(2, 1'b1));
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        n = 0;
        while (!(done2 && !busy2) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL timeout2: got no done after %0d cycles", n);
        end
        repeat (2) @(negedge clk);
        check("inv_err", 32'(err_count2), 32'd512);
        check("inv_ffa", 32'(ffa2), 32'd0);
        check("inv_ffp", 32'(ffp2), 32'd0);

        check("rq_empty", 32'(rq.size()), 32'd0);
        check("rq2_empty", 32'(rq2.size()), 32'd0);
        check("wq_empty", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
